// File: rtl/simple_mem_responder_if.sv
// -----------------------------------------------------------------------------
// simple_mem_responder_if
//   Request/acknowledge memory bus between a CPU load/store path (master)
//   and a memory responder (slave).
//
//   req    master -> slave  request valid, held with addr/we/wdata until ack
//   we     master -> slave  1 = write, 0 = read
//   addr   master -> slave  word address
//   wdata  master -> slave  write data
//   ack    slave -> master  one-cycle completion pulse
//   rdata  slave -> master  read data, meaningful only while ack=1 on a read
//   err    slave -> master  error completion, qualified by ack
//   busy   slave -> master  responder is holding an accepted request
// -----------------------------------------------------------------------------
interface simple_mem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err, busy
    );
endinterface

// File: rtl/simple_mem_responder.sv
// -----------------------------------------------------------------------------
// simple_mem_responder
//   Single-port data memory answering the CPU request/acknowledge bus.
//   One request is latched at a time, WAIT_CYCLES wait states are inserted,
//   then a one-cycle ack either commits the write or presents the read data.
//
//   Parameters
//     DATA_W       data bus / memory word width
//     ADDR_W       address bus width
//     DEPTH        number of words, power of two, 2..2^ADDR_W
//     WAIT_CYCLES  wait states between accept and ack, 0..15
//
//   Ports
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   simple_mem_responder_if.slave (req/we/addr/wdata in,
//           ack/rdata/err/busy out)
//
//   Build option
//     SIMPLE_MEM_ERR_EN  when defined, addr >= DEPTH completes with err=1,
//                        rdata=0 and writes are discarded. When undefined,
//                        err is tied low and addresses alias modulo DEPTH.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for req; accepts and latches the request
//   ST_WAIT   | wait states; down-counter runs until terminal count 1
//   ST_RESP   | ack pulse; read data presented or write committed
// -----------------------------------------------------------------------------
module simple_mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    simple_mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [3:0]        wait_cnt;
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              in_range;
    logic              accept;
    logic              in_resp;

    logic [DATA_W-1:0] mem [DEPTH];

    assign accept  = (state == ST_IDLE) && bus.req;
    assign in_resp = (state == ST_RESP);

`ifdef SIMPLE_MEM_ERR_EN
    // Widened by one bit so DEPTH == 2^ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    logic oor_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            oor_q <= 1'b0;
        end else if (accept) begin
            oor_q <= ({1'b0, bus.addr} >= DEPTH_LIM);
        end
    end

    assign in_range = ~oor_q;
    assign bus.err  = in_resp && oor_q;
`else
    // Upper address bits are ignored: the memory aliases modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr;

    assign in_range = 1'b1;
    assign bus.err  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    state_nxt = (WAIT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q     <= bus.we;
                idx_q    <= bus.addr[IDX_W-1:0];
                wdata_q  <= bus.wdata;
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Storage is not reset; rst only blocks a commit on the RESP edge.
    always_ff @(posedge clk) begin
        if (!rst && in_resp && we_q && in_range) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.ack   = in_resp;
    assign bus.busy  = (state != ST_IDLE);
    assign bus.rdata = (in_resp && !we_q && in_range) ? mem[idx_q] : '0;

endmodule
